// File: rtl/block_coef_tx_pkg.sv
// Framing shared by the coefficient loader and this readback transmitter:
// state encoding, default bank geometry and byte order on the wire.
package block_coef_tx_pkg;

    localparam int N_COEF_DEF = 16;
    localparam int COEF_W_DEF = 12;
    localparam bit HI_FIRST   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_HI,
        SEND_LO,
        DONE
    } tx_state_e;

    // Pick one byte of a coefficient already zero-extended to 16 bits.
    function automatic logic [7:0] coef_byte(input logic [15:0] c, input logic hi);
        return hi ? c[15:8] : c[7:0];
    endfunction

endpackage

// File: rtl/block_coef_tx_coef_bank_snap.sv
// Snapshot of the whole coefficient bank, taken in one cycle, with an
// indexed read port for the byte serializer.
module coef_bank_snap #(
    parameter int N_COEF = 16,
    parameter int COEF_W = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_i,
    input  logic [N_COEF*COEF_W-1:0]   bank_i,
    input  logic [$clog2(N_COEF)-1:0]  idx_i,
    output logic [COEF_W-1:0]          coef_o
);

    // Packed layout matches the flattened bus: entry k sits at [k*COEF_W +: COEF_W].
    logic [N_COEF-1:0][COEF_W-1:0] snap_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_q <= '0;
        end else if (load_i) begin
            snap_q <= bank_i;
        end
    end

    assign coef_o = snap_q[idx_i];

endmodule

// File: rtl/block_coef_tx.sv
// Coefficient readback transmitter: snapshots the bank on a start pulse and
// streams every coefficient as two bytes over a valid/ready byte link.
module block_coef_tx
    import block_coef_tx_pkg::*;
#(
    parameter int N_COEF = N_COEF_DEF,
    parameter int COEF_W = COEF_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_COEF*COEF_W-1:0]   coef_bank_i,
    input  logic                       pulsador_envio_coef_i,
    input  logic                       abort_i,
    input  logic                       byte_ready_i,
    output logic [7:0]                 byte_o,
    output logic                       byte_valid_o,
    output logic                       busy_o,
    output logic [$clog2(N_COEF)-1:0]  coef_idx_o,
    output logic                       fin_tx_coef_o
);

    localparam int IDX_W = $clog2(N_COEF);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEF - 1);

    tx_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [COEF_W-1:0] coef;
    logic [15:0]       coef_ext;
    logic              sending;

    coef_bank_snap #(
        .N_COEF (N_COEF),
        .COEF_W (COEF_W)
    ) u_snap (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == LOAD),
        .bank_i (coef_bank_i),
        .idx_i  (idx_q),
        .coef_o (coef)
    );

    assign coef_ext = 16'(coef);
    assign sending  = (state_q == SEND_HI) || (state_q == SEND_LO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Abort outranks everything, including a byte handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (abort_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pulsador_envio_coef_i) state_d = LOAD;
                end
                LOAD: begin
                    idx_d   = '0;
                    state_d = SEND_HI;
                end
                SEND_HI: begin
                    if (byte_ready_i) state_d = SEND_LO;
                end
                SEND_LO: begin
                    if (byte_ready_i) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = SEND_HI;
                        end
                    end
                end
                DONE: begin
                    idx_d   = '0;
                    state_d = IDLE;
                end
                default: begin
                    idx_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs decode purely from registered state, so byte_o holds while stalled.
    always_comb begin
        byte_o        = 8'h00;
        byte_valid_o  = 1'b0;
        busy_o        = 1'b0;
        coef_idx_o    = '0;
        fin_tx_coef_o = 1'b0;
        if (sending) begin
            byte_o       = coef_byte(coef_ext, (state_q == SEND_HI) == HI_FIRST);
            byte_valid_o = 1'b1;
            busy_o       = 1'b1;
            coef_idx_o   = idx_q;
        end
        if (state_q == LOAD) busy_o = 1'b1;
        if (state_q == DONE) fin_tx_coef_o = 1'b1;
    end

endmodule
